// File: rtl/tank_uart_tx_scheduler.sv
// tank_uart_tx_scheduler: snapshots tank state on divided vsync rises and
// streams it as a 9-byte packet over a valid/ready byte link.
module tank_uart_tx_scheduler #(
    parameter int unsigned FRAME_DIV = 2,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       select_mode,
    input  logic [9:0] xpos_UART,
    input  logic [9:0] ypos_UART,
    input  logic [1:0] direction_tank,
    input  logic [9:0] xpos_bullet,
    input  logic [9:0] ypos_bullet,
    input  logic       tank_hit,
    input  logic [2:0] direction_for_enemy,
    input  logic [7:0] HP_our_state,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       frame_sent,
    output logic       hit_pending,
    output logic [7:0] dropped_frames
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t          state_q, state_d;
    logic            vsync_q;
    logic [7:0]      frame_cnt_q, frame_cnt_d, drop_q, drop_d, tx_data_q, tx_data_d;
    logic            hit_q, hit_d, tx_valid_q, tx_valid_d, sent_q, sent_d;
    logic [3:0]      idx_q, idx_d;
    logic [8:1][7:0] pkt_q, pkt_d;
    logic            rise, trigger, capture;
    logic [39:0]     pos;

    assign rise    = vsync & ~vsync_q;
    assign trigger = rise & (hit_q | (frame_cnt_q == 8'(FRAME_DIV - 1)));
    assign capture = trigger & (state_q == IDLE);
    assign pos     = {xpos_UART, ypos_UART, xpos_bullet, ypos_bullet};

    always_comb begin
        frame_cnt_d = trigger ? 8'd0 : (rise ? frame_cnt_q + 8'd1 : frame_cnt_q);
        // a capture consumes any pending hit, including one arriving this cycle
        hit_d       = capture ? 1'b0 : (hit_q | tank_hit);
        drop_d      = (trigger && state_q != IDLE && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        state_d     = state_q;
        pkt_d       = pkt_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        sent_d      = 1'b0;
        case (state_q)
            IDLE: if (capture) begin
                state_d  = LOAD;
                pkt_d[1] = {select_mode, hit_q | tank_hit, direction_for_enemy, direction_tank, 1'b0};
                pkt_d[2] = pos[39:32];
                pkt_d[3] = pos[31:24];
                pkt_d[4] = pos[23:16];
                pkt_d[5] = pos[15:8];
                pkt_d[6] = pos[7:0];
                pkt_d[7] = HP_our_state;
            end
            LOAD: begin
                pkt_d[8]   = pkt_q[1] ^ pkt_q[2] ^ pkt_q[3] ^ pkt_q[4] ^ pkt_q[5] ^ pkt_q[6] ^ pkt_q[7];
                idx_d      = 4'd0;
                tx_data_d  = SYNC_BYTE;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: if (tx_valid_q && tx_ready) begin
                if (idx_q == 4'd8) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    sent_d     = 1'b1;
                end else begin
                    idx_d     = idx_q + 4'd1;
                    tx_data_d = pkt_q[idx_q + 4'd1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            vsync_q     <= 1'b1;
            frame_cnt_q <= 8'd0;
            drop_q      <= 8'd0;
            tx_data_q   <= 8'd0;
            hit_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            sent_q      <= 1'b0;
            idx_q       <= 4'd0;
            pkt_q       <= '0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync;
            frame_cnt_q <= frame_cnt_d;
            drop_q      <= drop_d;
            tx_data_q   <= tx_data_d;
            hit_q       <= hit_d;
            tx_valid_q  <= tx_valid_d;
            sent_q      <= sent_d;
            idx_q       <= idx_d;
            pkt_q       <= pkt_d;
        end
    end

    assign tx_data        = tx_data_q;
    assign tx_valid       = tx_valid_q;
    assign busy           = state_q != IDLE;
    assign frame_sent     = sent_q;
    assign hit_pending    = hit_q;
    assign dropped_frames = drop_q;
endmodule
